// File: rtl/instruction_fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instruction_fetch_pkg                                                |
// | Shared core constants: fetch FSM encoding, reset vector, opcodes.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package instruction_fetch_pkg;

    localparam logic [31:0] C_RESET_VECTOR   = 32'h0000_0000;
    localparam int unsigned C_PREFETCH_DEPTH = 2;

    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t ST_READY = 2'd0;
    localparam fetch_state_t ST_WAIT  = 2'd1;
    localparam fetch_state_t ST_DRAIN = 2'd2;

    localparam logic [6:0] C_OPC_LOAD   = 7'b000_0011;
    localparam logic [6:0] C_OPC_OP_IMM = 7'b001_0011;
    localparam logic [6:0] C_OPC_STORE  = 7'b010_0011;
    localparam logic [6:0] C_OPC_OP     = 7'b011_0011;
    localparam logic [6:0] C_OPC_BRANCH = 7'b110_0011;
    localparam logic [6:0] C_OPC_JAL    = 7'b110_1111;

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_prefetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prefetch_queue                                                       |
// | Synchronous circular FIFO with push, pop, flush and occupancy count. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module prefetch_queue #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    input  logic                         flush,
    output logic [WIDTH-1:0]             head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             w_full;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = pop && !w_empty;
    assign w_do_push = push && (!w_full || w_do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !flush) r_mem[r_wr_ptr] <= push_data;
    end

    assign head_data = r_mem[r_rd_ptr];
    assign count     = r_count;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instruction_fetch                                                    |
// | Single-outstanding prefetcher feeding the core from a word queue.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR   = C_RESET_VECTOR,
    parameter int unsigned PREFETCH_DEPTH = C_PREFETCH_DEPTH
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] program_counter,
    input  logic        instruction_accept,
    output logic [31:0] program_memory_value,
    output logic        instruction_valid,
    output logic        fetch_request,
    output logic [31:0] fetch_address,
    input  logic        fetch_ready,
    input  logic        fetch_response_valid,
    input  logic [31:0] fetch_response_data
);

    localparam int unsigned CW = $clog2(PREFETCH_DEPTH + 1);

    fetch_state_t  r_state;
    fetch_state_t  w_state_next;
    logic [31:2]   r_fetch_pointer;
    logic [31:2]   r_stream_base;
    logic          w_redirect;
    logic          w_handshake;
    logic          w_push;
    logic          w_pop;
    logic          w_q_nonempty;
    logic [CW-1:0] w_q_count;
    logic [31:0]   w_q_head;
    logic          w_unused_pc;

    assign w_unused_pc  = ^program_counter[1:0];
    assign w_redirect   = (program_counter[31:2] != r_stream_base);
    assign w_q_nonempty = (w_q_count != '0);
    assign w_handshake  = fetch_request && fetch_ready;
    // A redirect in the response cycle discards the word instead of queueing it.
    assign w_push       = (r_state == ST_WAIT) && fetch_response_valid && !w_redirect;
    assign w_pop        = instruction_valid && instruction_accept;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_READY;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_READY: if (w_handshake) w_state_next = ST_WAIT;
            ST_WAIT: begin
                if (fetch_response_valid) w_state_next = ST_READY;
                else if (w_redirect)      w_state_next = ST_DRAIN;
            end
            ST_DRAIN: if (fetch_response_valid) w_state_next = ST_READY;
            default:  w_state_next = ST_READY;
        endcase
    end

    always_comb begin
        fetch_request        = 1'b0;
        instruction_valid    = 1'b0;
        program_memory_value = 32'h0;
        if (reset_n && (r_state == ST_READY) && (w_q_count < CW'(PREFETCH_DEPTH)) && !w_redirect)
            fetch_request = 1'b1;
        if (w_q_nonempty && !w_redirect) begin
            instruction_valid    = 1'b1;
            program_memory_value = w_q_head;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fetch_pointer <= RESET_VECTOR[31:2];
            r_stream_base   <= RESET_VECTOR[31:2];
        end else if (w_redirect) begin
            r_fetch_pointer <= program_counter[31:2];
            r_stream_base   <= program_counter[31:2];
        end else begin
            if (w_handshake) r_fetch_pointer <= r_fetch_pointer + 30'd1;
            if (w_pop)       r_stream_base   <= r_stream_base + 30'd1;
        end
    end

    assign fetch_address = {r_fetch_pointer, 2'b00};

    prefetch_queue #(
        .DEPTH (PREFETCH_DEPTH),
        .WIDTH (32)
    ) u_prefetch_queue (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (w_push),
        .push_data (fetch_response_data),
        .pop       (w_pop),
        .flush     (w_redirect),
        .head_data (w_q_head),
        .count     (w_q_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_instruction_fetch                                                 |
// | Randomized bench with a transaction-level fetch model and memory.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_instruction_fetch;

    localparam logic [31:0] RV    = 32'h0000_0000;
    localparam int          DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] program_counter = RV;
    logic        instruction_accept = 1'b0;
    logic [31:0] program_memory_value;
    logic        instruction_valid;
    logic        fetch_request;
    logic [31:0] fetch_address;
    logic        fetch_ready = 1'b0;
    logic        fetch_response_valid = 1'b0;
    logic [31:0] fetch_response_data = 32'h0;

    always #5 clk = ~clk;

    instruction_fetch #(
        .RESET_VECTOR   (RV),
        .PREFETCH_DEPTH (DEPTH)
    ) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .program_counter      (program_counter),
        .instruction_accept   (instruction_accept),
        .program_memory_value (program_memory_value),
        .instruction_valid    (instruction_valid),
        .fetch_request        (fetch_request),
        .fetch_address        (fetch_address),
        .fetch_ready          (fetch_ready),
        .fetch_response_valid (fetch_response_valid),
        .fetch_response_data  (fetch_response_data)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h required %h at cycle %0d", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'hC3A5_5A3C;
    endfunction

    // Reference model: words held in order as addresses, plus one request slot.
    logic [31:0] m_q[$];
    bit          m_busy, m_keep;
    logic [31:0] m_ptr = RV, m_base = RV, m_req_addr;

    bit          mem_pending = 0;
    logic [31:0] mem_addr;
    int          mem_cnt = 0;

    int acc_pct = 100, rdy_pct = 100, lat_min = 1, lat_max = 1, jump_pct = 0;
    bit rst_req = 0;
    logic [31:0] pc_next = RV;

    int          cyc = 0;
    int          first_valid_cyc = -1;
    logic [31:0] hs_log[$];
    int          hs_cyc[$];
    bit          obs_valid;
    logic [31:0] obs_value, obs_pc;

    task automatic model_reset();
        m_q.delete();
        m_busy = 0;
        m_keep = 0;
        m_ptr  = RV;
        m_base = RV;
    endtask

    task automatic tick();
        bit          resp, redirect, exp_valid, exp_req, m_hs, m_pop, hs, pop;
        logic [31:0] exp_value;
        @(negedge clk);
        cyc++;
        reset_n = !rst_req;
        rst_req = 0;
        program_counter      = pc_next;
        resp                 = mem_pending && (mem_cnt == 0);
        fetch_response_valid = resp;
        fetch_response_data  = resp ? mem_word(mem_addr) : $urandom;
        fetch_ready          = !mem_pending && ($urandom_range(99) < rdy_pct);
        instruction_accept   = ($urandom_range(99) < acc_pct);
        #1;
        if (!reset_n) model_reset();
        redirect  = (program_counter[31:2] != m_base[31:2]);
        exp_valid = reset_n && (m_q.size() > 0) && !redirect;
        exp_value = exp_valid ? mem_word(m_q[0]) : 32'h0;
        exp_req   = reset_n && !m_busy && (m_q.size() < DEPTH) && !redirect;
        check_value("instruction_valid", 32'(instruction_valid), 32'(exp_valid));
        check_value("program_memory_value", program_memory_value, exp_value);
        check_value("fetch_request", 32'(fetch_request), 32'(exp_req));
        if (exp_req) check_value("fetch_address", fetch_address, m_ptr);
        check_value("fetch_address_lsb", {30'b0, fetch_address[1:0]}, 32'h0);

        if (reset_n) begin
            m_hs  = exp_req && fetch_ready;
            m_pop = exp_valid && instruction_accept;
            if (redirect) begin
                m_q.delete();
                m_base = {program_counter[31:2], 2'b00};
                m_ptr  = m_base;
                if (m_busy) begin
                    if (resp) m_busy = 0;
                    else      m_keep = 0;
                end
            end else begin
                if (m_pop) begin
                    void'(m_q.pop_front());
                    m_base = m_base + 32'd4;
                end
                if (m_hs) begin
                    m_req_addr = m_ptr;
                    m_ptr  = m_ptr + 32'd4;
                    m_busy = 1;
                    m_keep = 1;
                end else if (m_busy && resp) begin
                    if (m_keep) m_q.push_back(m_req_addr);
                    m_busy = 0;
                end
            end
        end

        hs  = fetch_request && fetch_ready;
        pop = instruction_valid && instruction_accept;
        if (resp) mem_pending = 0;
        else if (mem_pending) mem_cnt--;
        if (hs) begin
            mem_pending = 1;
            mem_addr    = fetch_address;
            mem_cnt     = $urandom_range(lat_max, lat_min) - 1;
            hs_log.push_back(fetch_address);
            hs_cyc.push_back(cyc);
        end

        obs_valid = instruction_valid;
        obs_value = program_memory_value;
        obs_pc    = program_counter;
        if (instruction_valid && first_valid_cyc < 0) first_valid_cyc = cyc;

        pc_next = program_counter;
        if (pop) pc_next = program_counter + 32'd4;
        if (jump_pct > 0 && $urandom_range(99) < jump_pct) begin
            case ($urandom_range(2))
                0:       pc_next = {24'h0, $urandom_range(63) * 4};
                1:       pc_next = 32'hFFFF_FFE0 + $urandom_range(31);
                default: pc_next = $urandom;
            endcase
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        bit found;
        // Sequential start, latency 1, accept everything.
        rst_req = 1; tick();
        rst_req = 1; tick();
        hs_log.delete(); hs_cyc.delete(); first_valid_cyc = -1;
        repeat (12) tick();
        check_value("seq_hs_count", 32'(hs_log.size() >= 3), 32'd1);
        if (hs_log.size() >= 3) begin
            check_value("seq_addr0", hs_log[0], 32'h0);
            check_value("seq_addr1", hs_log[1], 32'h4);
            check_value("seq_addr2", hs_log[2], 32'h8);
            check_value("seq_valid_latency", 32'(first_valid_cyc - hs_cyc[0]), 32'd2);
        end

        // Core stall: queue fills to depth, requests stop.
        acc_pct = 0;
        repeat (6) tick();
        hs_log.delete();
        repeat (6) tick();
        check_value("stall_no_request", 32'(hs_log.size()), 32'd0);
        check_value("stall_valid", 32'(obs_valid), 32'd1);
        acc_pct = 100;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            found = (hs_log.size() > 0);
        end
        check_value("stall_resume", 32'(found), 32'd1);

        // Jump from 0x8 to 0x100 while 0xC is outstanding.
        lat_min = 3; lat_max = 3;
        pc_next = RV; rst_req = 1; tick();
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            found = (program_counter == 32'h8) && mem_pending && (mem_addr == 32'hC) && (mem_cnt >= 1);
        end
        check_value("jump_setup", 32'(found), 32'd1);
        pc_next = 32'h100;
        hs_log.delete();
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            found = obs_valid && (obs_pc == 32'h100);
        end
        check_value("jump_valid_seen", 32'(found), 32'd1);
        if (found) check_value("jump_data", obs_value, mem_word(32'h100));
        check_value("jump_hs_count", 32'(hs_log.size() > 0), 32'd1);
        if (hs_log.size() > 0) check_value("jump_first_addr", hs_log[0], 32'h100);

        // Sequential fetch across the top of the address space.
        lat_min = 1; lat_max = 2;
        pc_next = 32'hFFFF_FFF8;
        hs_log.delete();
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick();
            foreach (hs_log[k])
                if (hs_log[k] == 32'hFFFF_FFFC && k + 1 < hs_log.size()) begin
                    found = 1;
                    check_value("wrap_next_addr", hs_log[k+1], 32'h0);
                end
        end
        check_value("wrap_found", 32'(found), 32'd1);

        // Reset while a kept request is outstanding; its late response must be ignored.
        lat_min = 4; lat_max = 4;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            found = m_busy && m_keep && mem_pending && (mem_cnt >= 2);
        end
        check_value("rst_setup", 32'(found), 32'd1);
        rst_req = 1; pc_next = RV;
        tick();
        check_value("rst_valid", 32'(instruction_valid), 32'd0);
        check_value("rst_value", program_memory_value, 32'h0);
        check_value("rst_request", 32'(fetch_request), 32'd0);
        hs_log.delete();
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            found = (hs_log.size() > 0);
        end
        check_value("rst_refetch_seen", 32'(found), 32'd1);
        if (found) check_value("rst_refetch_addr", hs_log[0], RV);

        // Randomized traffic with jumps, stalls, back-pressure and resets.
        acc_pct = 60; rdy_pct = 70; lat_min = 1; lat_max = 3; jump_pct = 4;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(299) == 0) rst_req = 1;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_VECTOR, 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter PREFETCH_DEPTH, 2: prefetch queue entries (legal 2..8).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 program_counter  input  32  address the core wants executed now.
REQ-006 instruction_accept  input  1  core consumes program_memory_value this cycle.
REQ-007 program_memory_value  output  32  instruction word for program_counter.
REQ-008 instruction_valid  output  1  program_memory_value is the word at program_counter.
REQ-009 fetch_request  output  1  memory read request.
REQ-010 fetch_address  output  32  word address for the request; bits [1:0] always 00.
REQ-011 fetch_ready  input  1  memory accepts the request this cycle.
REQ-012 fetch_response_valid  input  1  read data returned.
REQ-013 fetch_response_data  input  32  returned instruction word.

Function
REQ-014 SHALL allow at most one outstanding memory request; responses arrive in order, no earlier than 1 cycle after acceptance.
REQ-015 SHALL hold registers: fetch_pointer (next address to request), stream_base (address expected at queue head), queue of PREFETCH_DEPTH words, state.
REQ-016 States SHALL be READY (no request outstanding), WAIT (request outstanding, response kept), DRAIN (request outstanding, response discarded).
REQ-017 In READY, fetch_request SHALL be 1 when queue occupancy < PREFETCH_DEPTH and no redirect is active; fetch_address = fetch_pointer.
REQ-018 On fetch_request && fetch_ready: fetch_pointer += 4 (mod 2^32, wraps 0xFFFF_FFFC -> 0) and READY -> WAIT.
REQ-019 In WAIT, fetch_response_valid SHALL push fetch_response_data into the queue and go to READY; a new request may issue the next cycle.
REQ-020 In DRAIN, fetch_response_valid SHALL drop the data and go to READY.
REQ-021 instruction_valid SHALL be 1 iff queue non-empty and program_counter[31:2] == stream_base[31:2]; program_memory_value = queue head, else 0.
REQ-022 A pushed word SHALL be visible at the outputs the cycle after the response (response->valid latency 1 cycle).
REQ-023 instruction_accept with instruction_valid SHALL pop the head and add 4 to stream_base; accept without valid SHALL be ignored.
REQ-024 Redirect: program_counter[31:2] != stream_base[31:2] SHALL flush the queue, load fetch_pointer and stream_base with {program_counter[31:2],2'b00}, WAIT -> DRAIN, and suppress fetch_request that cycle.
REQ-025 Push and pop in the same cycle SHALL both take effect; occupancy unchanged.
REQ-026 Redirect and response in the same cycle: the response SHALL be discarded, state -> READY.
REQ-027 Redirect in READY with request handshake same cycle SHALL NOT occur (request suppressed per REQ-024).
REQ-028 Queue full SHALL hold fetch_request at 0; no overflow, no data loss.

Reset
REQ-029 reset_n low SHALL immediately force: state READY, queue empty, fetch_pointer = stream_base = RESET_VECTOR, instruction_valid 0, program_memory_value 0, fetch_request 0.
REQ-030 Reset mid-transaction SHALL abandon the outstanding request; a late response after reset release SHALL be ignored because state is READY.

Structure
REQ-031 The state encoding and RESET_VECTOR default SHALL live in the shared core package alongside the opcode constants.
REQ-032 The queue SHALL be a sub-module prefetch_queue (synchronous FIFO with push, pop, flush, count).

Verification
REQ-033 Reset, PC=0, memory latency 1, accept every valid cycle -> requests 0x0,0x4,0x8 in order; first instruction_valid 2 cycles after first handshake.
REQ-034 Core stalls (accept=0) with depth 2 -> exactly 2 words queued, fetch_request held 0, no further requests until a pop.
REQ-035 Jump: PC 0x8 -> 0x100 while request for 0xC outstanding -> DRAIN, 0xC data dropped, next request 0x100, valid only with 0x100 data.
REQ-036 PC 0xFFFF_FFFC sequential -> next fetch_address 0x0000_0000.
REQ-037 Same-cycle push and pop with queue at 1 -> occupancy stays 1, head advances.
REQ-038 reset_n pulsed low during WAIT -> outputs zero immediately; response arriving after release not enqueued; refetch from RESET_VECTOR.
